// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake over a 2-entry skid buffer,
// with flush, control zeroing on bubbles and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W            = 8,
  parameter int unsigned DATA_W            = 96,
  parameter bit          CLR_DATA_ON_FLUSH = 1'b0,
  parameter int unsigned CNT_W             = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  logic in_fire;
  logic out_fire;
  logic valid;

  assign valid    = (state_q != StEmpty);
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Flush overrides any handshake seen in the same cycle.
      state_d     = StEmpty;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLR_DATA_ON_FLUSH) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = StFull;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Ready is a flop of next occupancy, so out_ready never reaches in_ready combinationally.
  assign in_ready_d = (state_d != StFull);

  always_comb begin
    stall_d = stall_q;
    if (clr_stats) begin
      stall_d = '0;
    end else if (valid && !out_ready && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = valid;
  assign out_ctrl  = valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

endmodule
